// File: rtl/cti_counter_update_queue_pkg.sv
// Shared types, constants and the saturating counter step used by the
// CTI counter update queue and its request FIFO.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

package cti_counter_update_queue_pkg;

    localparam int CTI_LANES      = `FETCH_WIDTH;
    localparam int CTI_IDX_W      = 4;
    localparam int CTI_CNT_W      = 8;
    localparam int CTI_UPDQ_DEPTH = 8;
    localparam int CTI_UPDQ_IDX_W = $clog2(CTI_UPDQ_DEPTH);

    // One queued counter-update request.
    typedef struct packed {
        logic [CTI_IDX_W-1:0] index;
        logic                 inc;
    } cti_upd_t;

    // Unsigned +/-1 that sticks at both ends of the counter range.
    function automatic logic [CTI_CNT_W-1:0] cti_sat_step(
        input logic [CTI_CNT_W-1:0] old,
        input logic                 inc
    );
        logic [CTI_CNT_W-1:0] res;
        if (inc) begin
            if (old == {CTI_CNT_W{1'b1}}) begin
                res = old;
            end else begin
                res = old + CTI_CNT_W'(1);
            end
        end else begin
            if (old == {CTI_CNT_W{1'b0}}) begin
                res = old;
            end else begin
                res = old - CTI_CNT_W'(1);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cti_counter_update_queue_fifo.sv
// Multi-push, single-pop circular request queue. Valid lanes of an accepted
// bundle are packed in lane order into consecutive tail slots; acceptance is
// all-or-nothing based on free space. Flush and reset clear the pointers.
module cti_upd_fifo
    import cti_counter_update_queue_pkg::*;
#(
    parameter int LANES  = CTI_LANES,
    parameter int QDEPTH = CTI_UPDQ_DEPTH,
    parameter int QIDX   = CTI_UPDQ_IDX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic [LANES-1:0]      push_valid_i,
    input  cti_upd_t [LANES-1:0]  push_data_i,
    input  logic                  pop_i,
    output cti_upd_t              head_o,
    output logic                  empty_o,
    output logic                  ready_o,
    output logic [QIDX:0]         occupancy_o
);

    cti_upd_t        r_mem [QDEPTH];
    logic [QIDX-1:0] r_head;
    logic [QIDX-1:0] r_tail;
    logic [QIDX:0]   r_count;

    logic [QIDX-1:0] w_slot [LANES];
    logic [QIDX:0]   w_push_cnt;
    logic [QIDX:0]   w_free;
    logic            w_accept;
    logic            w_pop;

    assign w_free      = (QIDX+1)'(QDEPTH) - r_count;
    assign ready_o     = (w_free >= (QIDX+1)'(LANES));
    assign empty_o     = (r_count == (QIDX+1)'(0));
    assign w_accept    = ready_o && !flush_i && !reset;
    assign w_pop       = pop_i && !empty_o && !flush_i;
    assign head_o      = r_mem[r_head];
    assign occupancy_o = r_count;

    // Running count of valid lanes gives each lane its compacted tail slot.
    always_comb begin
        w_push_cnt = (QIDX+1)'(0);
        for (int k = 0; k < LANES; k++) begin
            w_slot[k] = r_tail + w_push_cnt[QIDX-1:0];
            if (push_valid_i[k]) begin
                w_push_cnt = w_push_cnt + (QIDX+1)'(1);
            end else begin
                w_push_cnt = w_push_cnt;
            end
        end
    end

    // Head/tail pointers and occupancy; flush and reset empty the queue.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            r_head  <= QIDX'(0);
            r_tail  <= QIDX'(0);
            r_count <= (QIDX+1)'(0);
        end else begin
            if (w_pop) begin
                r_head <= r_head + QIDX'(1);
            end else begin
                r_head <= r_head;
            end
            if (w_accept) begin
                r_tail  <= r_tail + w_push_cnt[QIDX-1:0];
                r_count <= r_count + w_push_cnt - (QIDX+1)'(w_pop);
            end else begin
                r_tail  <= r_tail;
                r_count <= r_count - (QIDX+1)'(w_pop);
            end
        end
    end

    // Entry storage; contents are meaningful only between head and tail.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (w_accept && push_valid_i[k]) begin
                r_mem[w_slot[k]] <= push_data_i[k];
            end
        end
    end

endmodule

// File: rtl/cti_counter_update_queue.sv
// Producer side of the CTI counter table: buffers per-lane update requests
// and retires one per cycle as a saturating read-modify-write, forwarding the
// registered write when the next pop targets the same index.
module cti_counter_update_queue
    import cti_counter_update_queue_pkg::*;
#(
    parameter int LANES  = CTI_LANES,
    parameter int INDEX  = CTI_IDX_W,
    parameter int WIDTH  = CTI_CNT_W,
    parameter int QDEPTH = CTI_UPDQ_DEPTH,
    parameter int QIDX   = CTI_UPDQ_IDX_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES-1:0]       upd_valid_i,
    input  logic [LANES*INDEX-1:0] upd_index_i,
    input  logic [LANES-1:0]       upd_inc_i,
    output logic                   upd_ready_o,
    input  logic                   flush_i,
    output logic [INDEX-1:0]       rd_addr_o,
    input  logic [WIDTH-1:0]       rd_data_i,
    output logic [INDEX-1:0]       wr_addr_o,
    output logic [WIDTH-1:0]       wr_data_o,
    output logic                   wr_en_o,
    output logic [QIDX:0]          occupancy_o,
    output logic                   busy_o
);

    cti_upd_t [LANES-1:0] w_push_data;
    cti_upd_t             w_head;
    logic                 w_empty;
    logic                 w_ready;
    logic                 w_pop;
    logic                 w_fwd;
    logic [WIDTH-1:0]     w_old;
    logic [WIDTH-1:0]     w_new;

    logic                 r_wr_en;
    logic [INDEX-1:0]     r_wr_addr;
    logic [WIDTH-1:0]     r_wr_data;

    // Split the flat lane buses into queue entries.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_push_data[k].index = upd_index_i[k*INDEX +: INDEX];
            w_push_data[k].inc   = upd_inc_i[k];
        end
    end

    cti_upd_fifo #(
        .LANES  (LANES),
        .QDEPTH (QDEPTH),
        .QIDX   (QIDX)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush_i),
        .push_valid_i (upd_valid_i),
        .push_data_i  (w_push_data),
        .pop_i        (w_pop),
        .head_o       (w_head),
        .empty_o      (w_empty),
        .ready_o      (w_ready),
        .occupancy_o  (occupancy_o)
    );

    // The head retires every non-empty cycle unless a flush is discarding it.
    assign w_pop = !w_empty && !flush_i;
    assign w_fwd = r_wr_en && (r_wr_addr == w_head.index);

    // Old value: the pending write is not yet visible through the table read.
    always_comb begin
        if (w_fwd) begin
            w_old = r_wr_data;
        end else begin
            w_old = rd_data_i;
        end
    end

    assign w_new = cti_sat_step(w_old, w_head.inc);

    // Register the table write for the popped request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= INDEX'(0);
            r_wr_data <= WIDTH'(0);
        end else begin
            r_wr_en <= w_pop;
            if (w_pop) begin
                r_wr_addr <= w_head.index;
                r_wr_data <= w_new;
            end else begin
                r_wr_addr <= r_wr_addr;
                r_wr_data <= r_wr_data;
            end
        end
    end

    assign rd_addr_o   = w_head.index;
    assign wr_en_o     = r_wr_en;
    assign wr_addr_o   = r_wr_addr;
    assign wr_data_o   = r_wr_data;
    assign upd_ready_o = w_ready;
    assign busy_o      = !w_empty || r_wr_en;

endmodule

// File: tb/tb_cti_counter_update_queue.sv
// Self-checking bench: table-driven vectors plus hand sequences, with a
// request/write scoreboard and a behavioural model of the counter table.
module tb_cti_counter_update_queue;

    localparam int LANES  = 4;
    localparam int INDEX  = 4;
    localparam int WIDTH  = 8;
    localparam int QDEPTH = 8;
    localparam int QIDX   = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [LANES-1:0]       upd_valid_i;
    logic [LANES*INDEX-1:0] upd_index_i;
    logic [LANES-1:0]       upd_inc_i;
    logic                   upd_ready_o;
    logic                   flush_i;
    logic [INDEX-1:0]       rd_addr_o;
    logic [WIDTH-1:0]       rd_data_i;
    logic [INDEX-1:0]       wr_addr_o;
    logic [WIDTH-1:0]       wr_data_o;
    logic                   wr_en_o;
    logic [QIDX:0]          occupancy_o;
    logic                   busy_o;

    always #5 clk = ~clk;

    cti_counter_update_queue #(
        .LANES(LANES), .INDEX(INDEX), .WIDTH(WIDTH), .QDEPTH(QDEPTH), .QIDX(QIDX)
    ) dut (
        .clk(clk), .reset(reset),
        .upd_valid_i(upd_valid_i), .upd_index_i(upd_index_i), .upd_inc_i(upd_inc_i),
        .upd_ready_o(upd_ready_o), .flush_i(flush_i),
        .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_en_o(wr_en_o),
        .occupancy_o(occupancy_o), .busy_o(busy_o)
    );

    typedef struct { logic [3:0] idx; logic inc; } req_t;
    typedef struct { logic [3:0] addr; logic [7:0] data; } wr_t;
    typedef struct { logic [3:0] v; logic [15:0] idx; logic [3:0] inc; int exp_occ; } vec_t;

    req_t       mq[$];
    wr_t        exp_wq[$];
    logic [7:0] ref_tbl [16];
    logic [7:0] tbl [16];
    logic       tb_load;
    int         m_occ;
    logic       exp_we;
    int         n_checks;
    int         n_fail;
    vec_t       vecs [17];

    function automatic logic [7:0] init_val(input int i);
        case (i)
            1:       return 8'd100;
            2:       return 8'd0;
            3:       return 8'd5;
            5:       return 8'd10;
            7:       return 8'd255;
            9:       return 8'd40;
            default: return 8'(i * 16 + 1);
        endcase
    endfunction

    function automatic logic [7:0] model_step(input logic [7:0] old, input logic inc);
        if (inc) return (old == 8'd255) ? old : old + 8'd1;
        else     return (old == 8'd0)   ? old : old - 8'd1;
    endfunction

    // Counter table: combinational read, posedge write.
    always @(posedge clk) begin
        if (tb_load) begin
            for (int i = 0; i < 16; i++) tbl[i] <= init_val(i);
        end else if (wr_en_o) begin
            tbl[wr_addr_o] <= wr_data_o;
        end
    end
    assign rd_data_i = tbl[rd_addr_o];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: update model/scoreboard, clock, then check.
    task automatic step(input logic [3:0] v, input logic [15:0] idx, input logic [3:0] inc,
                        input logic fl, input logic rs, output logic acc);
        logic ready_pre;
        logic pop;
        req_t r;
        wr_t  w;
        upd_valid_i = v;
        upd_index_i = idx;
        upd_inc_i   = inc;
        flush_i     = fl;
        reset       = rs;
        acc         = 1'b0;
        if (rs) begin
            mq.delete();
            exp_wq.delete();
            m_occ  = 0;
            exp_we = 1'b0;
        end else begin
            ready_pre = ((QDEPTH - m_occ) >= LANES);
            pop       = (mq.size() != 0) && !fl;
            exp_we    = pop;
            if (pop) begin
                r      = mq.pop_front();
                w.addr = r.idx;
                w.data = model_step(ref_tbl[r.idx], r.inc);
                ref_tbl[r.idx] = w.data;
                exp_wq.push_back(w);
                m_occ--;
            end
            if (fl) begin
                mq.delete();
                m_occ = 0;
            end else if (ready_pre) begin
                acc = 1'b1;
                for (int k = 0; k < LANES; k++) begin
                    if (v[k]) begin
                        r.idx = idx[4*k +: 4];
                        r.inc = inc[k];
                        mq.push_back(r);
                        m_occ++;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("wr_en", 32'(wr_en_o), 32'(exp_we));
        if (wr_en_o === 1'b1) begin
            if (exp_wq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_unexpected: got write addr %0d data %0d, required none", wr_addr_o, wr_data_o);
            end else begin
                w = exp_wq.pop_front();
                chk("wr_addr", 32'(wr_addr_o), 32'(w.addr));
                chk("wr_data", 32'(wr_data_o), 32'(w.data));
            end
        end else begin
            exp_wq.delete();
        end
        chk("occupancy", 32'(occupancy_o), 32'(m_occ));
        chk("ready", 32'(upd_ready_o), 32'((QDEPTH - m_occ) >= LANES));
        chk("busy", 32'(busy_o), 32'((m_occ != 0) || exp_we));
        if (mq.size() != 0) chk("rd_addr", 32'(rd_addr_o), 32'(mq[0].idx));
    endtask

    task automatic drain();
        logic acc;
        for (int c = 0; c < 30; c++) begin
            if (mq.size() == 0 && !exp_we) break;
            step(4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, acc);
        end
    endtask

    initial begin
        logic        acc;
        logic [15:0] bidx;
        logic [3:0]  binc;
        int          accepted;

        n_checks = 0;
        n_fail   = 0;
        m_occ    = 0;
        exp_we   = 1'b0;
        tb_load  = 1'b1;
        for (int i = 0; i < 16; i++) ref_tbl[i] = init_val(i);

        vecs[0]  = '{4'b0001, 16'h0003, 4'b0001, 1};
        vecs[1]  = '{4'b0000, 16'h0000, 4'b0000, 0};
        vecs[2]  = '{4'b0000, 16'h0000, 4'b0000, 0};
        vecs[3]  = '{4'b0001, 16'h0007, 4'b0001, 1};
        vecs[4]  = '{4'b0001, 16'h0002, 4'b0000, 1};
        vecs[5]  = '{4'b0000, 16'h0000, 4'b0000, 0};
        vecs[6]  = '{4'b0000, 16'h0000, 4'b0000, 0};
        vecs[7]  = '{4'b1010, 16'h1090, 4'b0010, 2};
        vecs[8]  = '{4'b0000, 16'h0000, 4'b0000, 1};
        vecs[9]  = '{4'b0000, 16'h0000, 4'b0000, 0};
        vecs[10] = '{4'b0000, 16'h0000, 4'b0000, 0};
        vecs[11] = '{4'b1111, 16'hA864, 4'b0101, 4};
        vecs[12] = '{4'b0000, 16'h0000, 4'b0000, 3};
        vecs[13] = '{4'b0000, 16'h0000, 4'b0000, 2};
        vecs[14] = '{4'b0000, 16'h0000, 4'b0000, 1};
        vecs[15] = '{4'b0000, 16'h0000, 4'b0000, 0};
        vecs[16] = '{4'b0000, 16'h0000, 4'b0000, 0};

        // Reset state.
        step(4'h0, 16'h0000, 4'h0, 1'b0, 1'b1, acc);
        tb_load = 1'b0;
        step(4'h0, 16'h0000, 4'h0, 1'b0, 1'b1, acc);
        chk("rst_wr_addr", 32'(wr_addr_o), 32'd0);
        chk("rst_wr_data", 32'(wr_data_o), 32'd0);
        chk("rst_occ", 32'(occupancy_o), 32'd0);
        step(4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, acc);
        chk("rst_ready", 32'(upd_ready_o), 32'd1);

        // Latency, saturation, sparse lanes, distinct-index bundle.
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].v, vecs[i].idx, vecs[i].inc, 1'b0, 1'b0, acc);
            chk("vec_occ", 32'(occupancy_o), 32'(vecs[i].exp_occ));
        end

        // Same-index forwarding: four back-to-back increments of index 5.
        step(4'hF, 16'h5555, 4'hF, 1'b0, 1'b0, acc);
        drain();
        chk("fwd_final", 32'(tbl[5]), 32'd14);

        // Backpressure: full bundles every cycle, held until accepted.
        for (int k = 0; k < LANES; k++) bidx[4*k +: 4] = 4'($urandom_range(15, 11));
        binc = 4'($urandom);
        accepted = 0;
        for (int c = 0; c < 40 && accepted < 6; c++) begin
            step(4'hF, bidx, binc, 1'b0, 1'b0, acc);
            if (acc) begin
                accepted++;
                for (int k = 0; k < LANES; k++) bidx[4*k +: 4] = 4'($urandom_range(15, 11));
                binc = 4'($urandom);
            end
        end
        chk("bp_bundles", 32'(accepted), 32'd6);
        drain();

        // Flush with six entries queued and a write in flight.
        step(4'hF, 16'hCDCD, 4'hF, 1'b0, 1'b0, acc);
        step(4'h7, 16'h0EEE, 4'h5, 1'b0, 1'b0, acc);
        chk("fl_pre_occ", 32'(occupancy_o), 32'd6);
        chk("fl_pre_we", 32'(wr_en_o), 32'd1);
        step(4'hF, 16'hBBBB, 4'hF, 1'b1, 1'b0, acc);
        chk("fl_occ", 32'(occupancy_o), 32'd0);
        chk("fl_we", 32'(wr_en_o), 32'd0);
        step(4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, acc);
        chk("fl_idle_we", 32'(wr_en_o), 32'd0);
        chk("fl_idle_busy", 32'(busy_o), 32'd0);

        // Same setup, aborted by reset instead.
        step(4'hF, 16'hCDCD, 4'hA, 1'b0, 1'b0, acc);
        step(4'h7, 16'h0EEE, 4'h2, 1'b0, 1'b0, acc);
        chk("rs_pre_we", 32'(wr_en_o), 32'd1);
        step(4'h0, 16'h0000, 4'h0, 1'b0, 1'b1, acc);
        chk("rs_we", 32'(wr_en_o), 32'd0);
        chk("rs_occ", 32'(occupancy_o), 32'd0);
        step(4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, acc);
        chk("rs_ready", 32'(upd_ready_o), 32'd1);
        drain();

        // Final table contents: every request applied exactly once.
        chk("tbl3", 32'(tbl[3]), 32'd6);
        chk("tbl7_sat", 32'(tbl[7]), 32'd255);
        chk("tbl2_sat", 32'(tbl[2]), 32'd0);
        chk("tbl9", 32'(tbl[9]), 32'd41);
        chk("tbl1", 32'(tbl[1]), 32'd99);
        for (int i = 0; i < 16; i++) chk("tbl_model", 32'(tbl[i]), 32'(ref_tbl[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
